accum_feedback_ctrl: RTL
========================

ACCUM_FEEDBACK_CTRL -- requirements
Module: accum_feedback_ctrl

Interface
REQ-001 Parameter: DATA_W, 24, accumulator data width excluding tag bit; legal range 8..32.
REQ-002 Parameter: PIPE_DEPTH, 4, adder pipeline latency in cycles before feedback is valid; legal range 1..15.
REQ-003 Parameter: NSLOT, 4, number of partial-sum capture slots; power of two, 2..16.
REQ-004 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-low reset.
REQ-006 Port: in_valid  input  1  element beat present this cycle.
REQ-007 Port: row_start  input  1  first element of a new row; qualified by in_valid.
REQ-008 Port: element  input  DATA_W+1  current matrix element; all-zero means end of stream.
REQ-009 Port: accum_valid  input  1  accum_in carries a new adder result.
REQ-010 Port: accum_in  input  DATA_W+1  adder result; bit DATA_W is the row-end tag.
REQ-011 Port: drain  input  1  request to unload all slots.
REQ-012 Port: feedback  output  DATA_W  value returned to the adder's second operand.
REQ-013 Port: fb_valid  output  1  feedback holds a live accumulator value.
REQ-014 Port: count  output  $clog2(PIPE_DEPTH+2)  beats since row_start.
REQ-015 Port: psum_out  output  DATA_W+1  drained slot value.
REQ-016 Port: psum_valid  output  1  psum_out valid this cycle.
REQ-017 Port: busy  output  1  drain in progress.

Function
REQ-018 count SHALL update as follows, in priority order:
- element==0: clear to 0.
- in_valid&&row_start: load 1.
- in_valid: increment, saturating at PIPE_DEPTH+1.
- Otherwise: hold.
REQ-019 The feedback FSM SHALL have states IDLE, FILL and FEED, with element==0 taking priority over all other transitions.
REQ-020 Transitions:
- Any state, element==0: go to IDLE.
- Any state, in_valid&&row_start: go to FILL; feedback<=0; fb_valid<=0.
- FILL, count==PIPE_DEPTH and no row_start: go to FEED; feedback<=accum_in[DATA_W-1:0]; fb_valid<=1.
- FEED: feedback<=accum_in[DATA_W-1:0] every cycle.
REQ-021 In IDLE, feedback SHALL be 0 and fb_valid SHALL be 0.
REQ-022 Slot capture, when not busy:
- accum_valid with accum_in[DATA_W]==1, or accum_in==0: slot[0]<=accum_in; slots 1..NSLOT-1 cleared; wr_ptr<=1.
- Otherwise accum_valid: slot[wr_ptr]<=accum_in; wr_ptr increments modulo NSLOT.
REQ-023 drain asserted while not busy SHALL set busy the next cycle and present slot[0]..slot[NSLOT-1] on psum_out, one per cycle, with psum_valid high for exactly NSLOT consecutive cycles.
REQ-024 busy SHALL fall in the cycle after the last slot is emitted; slots and wr_ptr SHALL then be cleared to 0.
REQ-025 While busy, slot captures SHALL be discarded and drain re-assertion SHALL be ignored.
REQ-026 Outputs SHALL be registered; feedback and psum_out have 1-cycle latency from their source inputs.

Reset
REQ-027 reset low at a clock edge SHALL force all of the following:
- count=0, FSM=IDLE, feedback=0, fb_valid=0.
- All slots=0, wr_ptr=0.
- psum_out=0, psum_valid=0, busy=0.
REQ-028 reset asserted mid-drain SHALL abort the drain with no further psum_valid pulses.

Configuration
REQ-029 Macro ACCUM_DRAIN_EN defined: REQ-023..REQ-025 and REQ-028 SHALL apply.
REQ-030 Macro ACCUM_DRAIN_EN undefined:
- drain SHALL be ignored.
- psum_out, psum_valid and busy SHALL be tied to 0.
- Slot capture SHALL run unconditionally.

Structure
REQ-031 Package accum_ctrl_pkg SHALL hold the FSM state enum (IDLE, FILL, FEED), the tag-bit position helper and the default parameter constants.
REQ-032 The slot array, wr_ptr and drain sequencer SHALL be a sub-module named psum_slot_bank.

Verification (DATA_W=24, PIPE_DEPTH=4, NSLOT=4)
REQ-033 Feedback start: row_start then 4 in_valid beats with accum_in=0x000010 -> feedback=0x000010 and fb_valid=1 in the cycle after count==4.
REQ-034 New row mid-stream: row_start while in FEED -> feedback=0, fb_valid=0 and count=1 the next cycle.
REQ-035 End of stream: element=0 while in FEED -> IDLE, count=0 and feedback=0 the next cycle.
REQ-036 Tag restart: accum_in=0x1000005 (tag set) followed by 0x000001, 0x000002 -> slots={0x1000005, 0x000001, 0x000002, 0}, wr_ptr=3.
REQ-037 Drain: drain pulse -> psum_valid high for 4 cycles emitting slots in order; a capture attempted during the drain is dropped; busy=0 and all slots=0 afterwards.
REQ-038 Reset mid-drain: reset low on the 2nd drain cycle -> psum_valid=0 and busy=0 from the next cycle; all outputs at reset values.

Source files
------------

// File: rtl/accum_ctrl_pkg.sv
// Shared definitions for the accumulator feedback controller: default
// parameter values, the feedback FSM state enum and the tag-bit locator.
package accum_ctrl_pkg;

  localparam int DATA_W_DEF     = 24;
  localparam int PIPE_DEPTH_DEF = 4;
  localparam int NSLOT_DEF      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FEED = 2'd2
  } fb_state_e;

  // The row-end tag sits just above the data field of an adder result.
  function automatic int tag_bit(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/psum_slot_bank.sv
// Partial-sum capture slots with an optional drain sequencer.
// Macro ACCUM_DRAIN_EN: when defined, a drain request unloads every slot in
// order on psum_out and captures are frozen while busy; when undefined the
// drain port is ignored, the drain outputs read 0 and capture never stops.
module psum_slot_bank
  import accum_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NSLOT  = NSLOT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              accum_valid,
  input  logic [DATA_W:0]   accum_in,
  input  logic              drain,
  output logic [DATA_W:0]   psum_out,
  output logic              psum_valid,
  output logic              busy
);

  localparam int IDXW = $clog2(NSLOT);
  localparam int TAG  = tag_bit(DATA_W);
  localparam logic [IDXW-1:0]  IDX_ZERO  = IDXW'(0);
  localparam logic [IDXW-1:0]  IDX_ONE   = IDXW'(1);
  localparam logic [DATA_W:0]  WORD_ZERO = {(DATA_W+1){1'b0}};

  logic [DATA_W:0] slot_r [NSLOT];
  logic [IDXW-1:0] wr_ptr_r;
  logic            cap_en_s;
  logic            drain_done_s;
  logic            restart_s;

  // A tagged result or an all-zero result begins a new capture group.
  assign restart_s = accum_valid && (accum_in[TAG] || (accum_in == WORD_ZERO));

`ifdef ACCUM_DRAIN_EN
  logic            busy_r;
  logic            psum_valid_r;
  logic [DATA_W:0] psum_r;
  logic [IDXW-1:0] rd_idx_r;

  // Read index wraps to zero once the last slot has been presented.
  assign drain_done_s = busy_r && (rd_idx_r == IDX_ZERO);
  assign cap_en_s     = !busy_r;

  // Drain sequencer: slot 0 goes out on the start edge, the rest follow.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_r       <= 1'b0;
      psum_valid_r <= 1'b0;
      psum_r       <= WORD_ZERO;
      rd_idx_r     <= IDX_ZERO;
    end else if (busy_r) begin
      if (rd_idx_r == IDX_ZERO) begin
        busy_r       <= 1'b0;
        psum_valid_r <= 1'b0;
        psum_r       <= WORD_ZERO;
      end else begin
        psum_r       <= slot_r[rd_idx_r];
        psum_valid_r <= 1'b1;
        rd_idx_r     <= rd_idx_r + IDX_ONE;
      end
    end else if (drain) begin
      busy_r       <= 1'b1;
      psum_valid_r <= 1'b1;
      psum_r       <= slot_r[0];
      rd_idx_r     <= IDX_ONE;
    end else begin
      psum_valid_r <= 1'b0;
      psum_r       <= WORD_ZERO;
    end
  end

  assign psum_out   = psum_r;
  assign psum_valid = psum_valid_r;
  assign busy       = busy_r;
`else
  logic drain_unused_s;

  assign drain_unused_s = drain;
  assign drain_done_s   = 1'b0;
  assign cap_en_s       = 1'b1;
  assign psum_out       = WORD_ZERO;
  assign psum_valid     = 1'b0;
  assign busy           = 1'b0;
`endif

  // Slot array: restart/append captures, wiped on reset and after a drain.
  always_ff @(posedge clock) begin
    if (!reset || drain_done_s) begin
      for (int i = 0; i < NSLOT; i++) slot_r[i] <= WORD_ZERO;
      wr_ptr_r <= IDX_ZERO;
    end else if (cap_en_s && restart_s) begin
      slot_r[0] <= accum_in;
      for (int i = 1; i < NSLOT; i++) slot_r[i] <= WORD_ZERO;
      wr_ptr_r <= IDX_ONE;
    end else if (cap_en_s && accum_valid) begin
      slot_r[wr_ptr_r] <= accum_in;
      wr_ptr_r         <= wr_ptr_r + IDX_ONE;
    end
  end

endmodule

// File: rtl/accum_feedback_ctrl.sv
// Accumulator feedback controller: beat counter, IDLE/FILL/FEED feedback
// FSM and a psum_slot_bank instance. Macro ACCUM_DRAIN_EN enables the
// slot drain path inside psum_slot_bank.
module accum_feedback_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int NSLOT      = NSLOT_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic                              row_start,
  input  logic [DATA_W:0]                   element,
  input  logic                              accum_valid,
  input  logic [DATA_W:0]                   accum_in,
  input  logic                              drain,
  output logic [DATA_W-1:0]                 feedback,
  output logic                              fb_valid,
  output logic [$clog2(PIPE_DEPTH+2)-1:0]   count,
  output logic [DATA_W:0]                   psum_out,
  output logic                              psum_valid,
  output logic                              busy
);

  localparam int CNT_W = $clog2(PIPE_DEPTH+2);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_PD   = CNT_W'(PIPE_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(PIPE_DEPTH + 1);
  localparam logic [DATA_W-1:0] FB_ZERO  = {DATA_W{1'b0}};
  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_FILL = 2'(ST_FILL);
  localparam logic [1:0] S_FEED = 2'(ST_FEED);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [DATA_W-1:0] fb_nxt_s;
  logic              fbv_nxt_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              eos_s;
  logic              start_s;

  assign eos_s   = (element == {(DATA_W+1){1'b0}});
  assign start_s = in_valid && row_start;

  // Beat counter: end-of-stream clears, row start loads 1, beats saturate.
  always_comb begin
    count_nxt_s = count;
    if (eos_s) begin
      count_nxt_s = CNT_ZERO;
    end else if (start_s) begin
      count_nxt_s = CNT_ONE;
    end else if (in_valid) begin
      count_nxt_s = (count == CNT_MAX) ? CNT_MAX : count + CNT_ONE;
    end else begin
      count_nxt_s = count;
    end
  end

  // Feedback FSM next state; end-of-stream outranks everything else.
  always_comb begin
    state_nxt_s = state_r;
    fb_nxt_s    = feedback;
    fbv_nxt_s   = fb_valid;
    if (eos_s) begin
      state_nxt_s = S_IDLE;
      fb_nxt_s    = FB_ZERO;
      fbv_nxt_s   = 1'b0;
    end else if (start_s) begin
      state_nxt_s = S_FILL;
      fb_nxt_s    = FB_ZERO;
      fbv_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        S_FILL: begin
          if (count == CNT_PD) begin
            state_nxt_s = S_FEED;
            fb_nxt_s    = accum_in[DATA_W-1:0];
            fbv_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = S_FILL;
          end
        end
        S_FEED: begin
          fb_nxt_s  = accum_in[DATA_W-1:0];
          fbv_nxt_s = 1'b1;
        end
        S_IDLE: begin
          fb_nxt_s  = FB_ZERO;
          fbv_nxt_s = 1'b0;
        end
        default: begin
          state_nxt_s = S_IDLE;
          fb_nxt_s    = FB_ZERO;
          fbv_nxt_s   = 1'b0;
        end
      endcase
    end
  end

  // Register counter, FSM state and feedback outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      feedback <= FB_ZERO;
      fb_valid <= 1'b0;
      count    <= CNT_ZERO;
    end else begin
      state_r  <= state_nxt_s;
      feedback <= fb_nxt_s;
      fb_valid <= fbv_nxt_s;
      count    <= count_nxt_s;
    end
  end

  psum_slot_bank #(
    .DATA_W (DATA_W),
    .NSLOT  (NSLOT)
  ) u_bank (
    .clock       (clock),
    .reset       (reset),
    .accum_valid (accum_valid),
    .accum_in    (accum_in),
    .drain       (drain),
    .psum_out    (psum_out),
    .psum_valid  (psum_valid),
    .busy        (busy)
  );

endmodule
